// File: rtl/somador_pkg.sv
// Shared types and constants for the somador_seq multi-precision add sequencer.
package somador_pkg;

    localparam int DATA_W      = 8;
    localparam int WORDS_W_DEF = 4;
    localparam int LAT_W       = 2;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        OUT,
        DONE
    } state_t;

endpackage

// File: rtl/somador_seq_latcnt.sv
// Adder latency down-counter: loaded with ADD_LAT on operand acceptance, flags zero.
module somador_seq_latcnt
    import somador_pkg::*;
#(
    parameter int ADD_LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    logic [LAT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LAT_W'(ADD_LAT);
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/somador_seq.sv
// Multi-precision add sequencer: streams byte pairs LSB-first through an external adder,
// chaining carry across words. Optional signed overflow output under SOMADOR_SEQ_OVF_EN.
module somador_seq
    import somador_pkg::*;
#(
    parameter int WORDS_W = WORDS_W_DEF,
    parameter int ADD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WORDS_W-1:0] n_words,
    input  logic              carry_in,
    output logic              busy,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    output logic [DATA_W-1:0] add_a,
    output logic [DATA_W-1:0] add_b,
    output logic              add_cin,
    input  logic [DATA_W-1:0] add_sum,
    input  logic              add_cout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_sum,
    output logic              out_last,
    output logic              done,
    output logic              carry_out
`ifdef SOMADOR_SEQ_OVF_EN
    ,
    output logic              ovf_o
`endif
);

    state_t               r_state;
    state_t               w_next;
    logic [WORDS_W-1:0]   r_remaining;
    logic                 r_carry;
    logic                 r_carry_out;
    logic [DATA_W-1:0]    r_add_a;
    logic [DATA_W-1:0]    r_add_b;
    logic                 r_add_cin;
    logic [DATA_W-1:0]    r_out_sum;
    logic                 r_out_last;
    logic                 w_lat_zero;
    logic                 w_start_ok;
    logic                 w_accept;
    logic                 w_capture;
    logic                 w_handshake;

    assign w_start_ok  = (r_state == IDLE) && start;
    assign w_accept    = (r_state == LOAD) && in_valid;
    assign w_capture   = (r_state == WAIT) && w_lat_zero;
    assign w_handshake = (r_state == OUT) && out_ready;

    somador_seq_latcnt #(
        .ADD_LAT (ADD_LAT)
    ) u_latcnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_accept),
        .i_dec  (r_state == WAIT),
        .o_zero (w_lat_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next = (n_words != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                if (in_valid) begin
                    w_next = WAIT;
                end
            end
            WAIT: begin
                if (w_lat_zero) begin
                    w_next = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    w_next = r_out_last ? DONE : LOAD;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // The final carry is published on the same edge that enters DONE, so it is valid with done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_remaining <= '0;
            r_carry     <= 1'b0;
            r_carry_out <= 1'b0;
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_add_cin   <= 1'b0;
            r_out_sum   <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_remaining <= n_words;
                r_carry     <= carry_in;
                if (n_words == '0) begin
                    r_carry_out <= carry_in;
                end
            end
            if (w_accept) begin
                r_add_a   <= a_in;
                r_add_b   <= b_in;
                r_add_cin <= r_carry;
            end
            if (w_capture) begin
                r_out_sum  <= add_sum;
                r_carry    <= add_cout;
                r_out_last <= (r_remaining == WORDS_W'(1));
            end
            if (w_handshake) begin
                r_remaining <= r_remaining - 1'b1;
                if (r_out_last) begin
                    r_carry_out <= r_carry;
                end
            end
        end
    end

`ifdef SOMADOR_SEQ_OVF_EN
    logic r_ovf_pend;
    logic r_ovf;

    // Overflow is judged on the most significant word only, then published alongside carry_out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_pend <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_start_ok && (n_words == '0)) begin
                r_ovf <= 1'b0;
            end
            if (w_capture) begin
                r_ovf_pend <= (r_add_a[DATA_W-1] == r_add_b[DATA_W-1]) &&
                              (add_sum[DATA_W-1] != r_add_a[DATA_W-1]);
            end
            if (w_handshake && r_out_last) begin
                r_ovf <= r_ovf_pend;
            end
        end
    end

    assign ovf_o = r_ovf;
`endif

    assign busy      = (r_state != IDLE);
    assign in_ready  = (r_state == LOAD);
    assign out_valid = (r_state == OUT);
    assign done      = (r_state == DONE);
    assign add_a     = r_add_a;
    assign add_b     = r_add_b;
    assign add_cin   = r_add_cin;
    assign out_sum   = r_out_sum;
    assign out_last  = r_out_last;
    assign carry_out = r_carry_out;

endmodule

// File: tb/tb_somador_seq.sv
// Self-checking bench for somador_seq: table-driven operations with a sum scoreboard,
// plus hand-written n_words=0, backpressure and mid-operation reset sequences.
module tb_somador_seq;
    import somador_pkg::*;

    localparam int WW     = 4;
    localparam int LAT    = 1;
    localparam int BUDGET = 50;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [WW-1:0] n_words = '0;
    logic          carry_in = 1'b0;
    logic          busy;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [7:0]    a_in = '0;
    logic [7:0]    b_in = '0;
    logic [7:0]    add_a;
    logic [7:0]    add_b;
    logic          add_cin;
    logic [7:0]    add_sum;
    logic          add_cout;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [7:0]    out_sum;
    logic          out_last;
    logic          done;
    logic          carry_out;
`ifdef SOMADOR_SEQ_OVF_EN
    logic          ovf_o;
`endif

    typedef struct {
        int               n;
        logic             cin;
        logic [2:0][7:0]  a;
        logic [2:0][7:0]  b;
        logic [2:0][7:0]  s;
        logic             cout;
        logic             ovf;
        int               stallWord;
        int               stallCycles;
    } op_t;

    typedef struct {
        logic [7:0] sum;
        logic       last;
    } exp_t;

    exp_t sb[$];
    op_t  ops[5];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // One-cycle registered adder standing in for the pad-ring adder core (ADD_LAT=1).
    logic [8:0] r_addRes = '0;
    always @(posedge clk) r_addRes <= {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};
    assign add_sum  = r_addRes[7:0];
    assign add_cout = r_addRes[8];

    somador_seq #(
        .WORDS_W (WW),
        .ADD_LAT (LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .n_words   (n_words),
        .carry_in  (carry_in),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .done      (done),
        .carry_out (carry_out)
`ifdef SOMADOR_SEQ_OVF_EN
        ,
        .ovf_o     (ovf_o)
`endif
    );

    function automatic op_t mkOp(input int n, input logic cin,
                                 input logic [7:0] a0, input logic [7:0] b0, input logic [7:0] s0,
                                 input logic [7:0] a1, input logic [7:0] b1, input logic [7:0] s1,
                                 input logic [7:0] a2, input logic [7:0] b2, input logic [7:0] s2,
                                 input logic cout, input logic ovf, input int sw, input int sc);
        op_t o;
        o.n = n;
        o.cin = cin;
        o.a = {a2, a1, a0};
        o.b = {b2, b1, b0};
        o.s = {s2, s1, s0};
        o.cout = cout;
        o.ovf = ovf;
        o.stallWord = sw;
        o.stallCycles = sc;
        return o;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int n, input logic cin);
        @(negedge clk);
        start    = 1'b1;
        n_words  = WW'(n);
        carry_in = cin;
        @(negedge clk);
        start    = 1'b0;
        n_words  = '0;
        carry_in = 1'b0;
    endtask

    task automatic sendWord(input logic [7:0] a, input logic [7:0] b, input logic [7:0] s,
                            input logic last, input string name);
        exp_t e;
        int cnt = 0;
        while (!in_ready && cnt < BUDGET) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput({name, "_inready_timeout"}, 32'(cnt < BUDGET), 32'd1);
        a_in = a;
        b_in = b;
        in_valid = 1'b1;
        e.sum = s;
        e.last = last;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        cnt = 0;
        while (!out_valid && cnt < BUDGET) begin
            checkOutput({name, "_inready_in_wait"}, 32'(in_ready), 32'd0);
            @(negedge clk);
            cnt++;
        end
        checkOutput({name, "_latency"}, 32'(cnt), 32'(LAT + 1));
    endtask

    task automatic recvWord(input int stall, input string name);
        exp_t e;
        out_ready = 1'b0;
        if (sb.size() == 0) begin
            checkOutput({name, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            for (int i = 0; i < stall; i++) begin
                checkOutput({name, "_stall_valid"}, 32'(out_valid), 32'd1);
                checkOutput({name, "_stall_sum"}, 32'(out_sum), 32'(sb[0].sum));
                checkOutput({name, "_stall_inready"}, 32'(in_ready), 32'd0);
                @(negedge clk);
            end
            e = sb.pop_front();
            checkOutput({name, "_valid"}, 32'(out_valid), 32'd1);
            checkOutput({name, "_sum"}, 32'(out_sum), 32'(e.sum));
            checkOutput({name, "_last"}, 32'(out_last), 32'(e.last));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic runOp(input op_t op, input string name);
        applyStimulus(op.n, op.cin);
        checkOutput({name, "_busy_start"}, 32'(busy), 32'd1);
        for (int w = 0; w < op.n; w++) begin
            sendWord(op.a[w], op.b[w], op.s[w], (w == op.n - 1), $sformatf("%s_w%0d", name, w));
            recvWord((w == op.stallWord) ? op.stallCycles : 0, $sformatf("%s_w%0d", name, w));
            if (w < op.n - 1) checkOutput({name, "_early_done"}, 32'(done), 32'd0);
        end
        checkOutput({name, "_done"}, 32'(done), 32'd1);
        checkOutput({name, "_busy_done"}, 32'(busy), 32'd1);
        checkOutput({name, "_carry_out"}, 32'(carry_out), 32'(op.cout));
`ifdef SOMADOR_SEQ_OVF_EN
        checkOutput({name, "_ovf"}, 32'(ovf_o), 32'(op.ovf));
`endif
        @(negedge clk);
        checkOutput({name, "_done_pulse"}, 32'(done), 32'd0);
        checkOutput({name, "_busy_idle"}, 32'(busy), 32'd0);
        checkOutput({name, "_carry_hold"}, 32'(carry_out), 32'(op.cout));
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_busy"}, 32'(busy), 32'd0);
        checkOutput({name, "_in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({name, "_add_a"}, 32'(add_a), 32'd0);
        checkOutput({name, "_add_b"}, 32'(add_b), 32'd0);
        checkOutput({name, "_add_cin"}, 32'(add_cin), 32'd0);
        checkOutput({name, "_out_valid"}, 32'(out_valid), 32'd0);
        checkOutput({name, "_out_sum"}, 32'(out_sum), 32'd0);
        checkOutput({name, "_out_last"}, 32'(out_last), 32'd0);
        checkOutput({name, "_done"}, 32'(done), 32'd0);
        checkOutput({name, "_carry_out"}, 32'(carry_out), 32'd0);
`ifdef SOMADOR_SEQ_OVF_EN
        checkOutput({name, "_ovf"}, 32'(ovf_o), 32'd0);
`endif
    endtask

    task automatic zeroWordOp(input logic cin, input string name);
        applyStimulus(0, cin);
        checkOutput({name, "_done"}, 32'(done), 32'd1);
        checkOutput({name, "_busy"}, 32'(busy), 32'd1);
        checkOutput({name, "_carry_out"}, 32'(carry_out), 32'(cin));
        checkOutput({name, "_in_ready"}, 32'(in_ready), 32'd0);
        checkOutput({name, "_out_valid"}, 32'(out_valid), 32'd0);
`ifdef SOMADOR_SEQ_OVF_EN
        checkOutput({name, "_ovf"}, 32'(ovf_o), 32'd0);
`endif
        @(negedge clk);
        checkOutput({name, "_done_pulse"}, 32'(done), 32'd0);
        checkOutput({name, "_in_ready_after"}, 32'(in_ready), 32'd0);
        checkOutput({name, "_carry_hold"}, 32'(carry_out), 32'(cin));
    endtask

    initial begin
        int cnt;
        op_t ovfOp;

        ops[0] = mkOp(1, 1'b0, 8'h3C, 8'h05, 8'h41, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                      1'b0, 1'b0, -1, 0);
        ops[1] = mkOp(3, 1'b1, 8'hFF, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h12, 8'h34, 8'h47,
                      1'b0, 1'b0, 1, 3);
        ops[2] = mkOp(2, 1'b0, 8'h80, 8'h80, 8'h00, 8'h01, 8'h02, 8'h04, 8'h00, 8'h00, 8'h00,
                      1'b0, 1'b0, 0, 5);
        ops[3] = mkOp(1, 1'b1, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                      1'b1, 1'b0, -1, 0);
        ops[4] = mkOp(2, 1'b0, 8'h00, 8'h01, 8'h01, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00,
                      1'b1, 1'b0, -1, 0);
        ovfOp  = mkOp(1, 1'b0, 8'h7F, 8'h01, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                      1'b0, 1'b1, -1, 0);

        #1 rst = 1'b1;
        #1 checkAllZero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 5; i++) begin
            runOp(ops[i], $sformatf("op%0d", i));
        end
        runOp(ovfOp, "ovf7F01");

        zeroWordOp(1'b0, "zero_c0");
        zeroWordOp(1'b1, "zero_c1");

        $display("[TB] reset during WAIT of word 2");
        applyStimulus(2, 1'b0);
        sendWord(8'h11, 8'h22, 8'h33, 1'b0, "rst_w0");
        recvWord(0, "rst_w0");
        cnt = 0;
        while (!in_ready && cnt < BUDGET) begin
            @(negedge clk);
            cnt++;
        end
        checkOutput("rst_w1_inready_timeout", 32'(cnt < BUDGET), 32'd1);
        a_in = 8'h44;
        b_in = 8'h55;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("rst_in_wait_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1 checkAllZero("rst_mid");
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("rst_no_done", 32'(done), 32'd0);
            checkOutput("rst_no_busy", 32'(busy), 32'd0);
        end
        runOp(ops[0], "after_rst");
        runOp(ops[1], "after_rst_chain");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "[TB] timeout");
    end

endmodule
